if_collapse_result_buffer: RTL and testbench
============================================

Name: if_collapse_result_buffer

Overview:
Downstream stage of the if-collapse micro benchmark. It consumes the registered results out0 / out1 / out2 of that block and queues qualified samples in a small first-word-fall-through FIFO. A consumer drains the FIFO with a valid/ready handshake. The block also keeps saturating statistics: accepted, dropped and out0/out2-match counts. It exists to exercise synthesis of pointer/counter logic, handshakes and nested if/else priority around a collapsed-if producer.

Parameters:
BITS, 2, width of out0/out2 operands (entry width = 2*BITS)
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of each statistics counter

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
out0_in  input  BITS  producer result out0
out1_in  input  1  producer out1; 1 = sample qualified (push request)
out2_in  input  BITS  producer result out2
flush  input  1  synchronous FIFO clear
rd_ready  input  1  consumer ready
rd_valid  output  1  FIFO not empty
rd_data  output  2*BITS  head entry {out2, out0}; out2 in MSBs
level  output  log2(DEPTH)+1  current occupancy
full  output  1  level == DEPTH
accept_cnt  output  CNT_W  pushes accepted (saturating)
drop_cnt  output  CNT_W  pushes rejected because FIFO full (saturating)
match_cnt  output  CNT_W  accepted pushes with out0_in == out2_in (saturating)

Behaviour:
- Reset (reset_n low, asynchronous): read and write pointers = 0; level = 0; rd_valid = 0; full = 0; all counters = 0. rd_data = 0 during reset. Storage contents after reset are don't-care and are not observable while rd_valid = 0.
- push = out1_in. pop = rd_valid & rd_ready.
- Write: on a rising edge with push and (not full, or pop in the same cycle), store {out2_in, out0_in} at wr_ptr. wr_ptr increments and wraps modulo DEPTH.
- Full with push and pop in the same cycle: both are accepted; level is unchanged.
- Full with push and no pop: entry is discarded; drop_cnt increments; accept_cnt is unchanged.
- Empty with push and rd_ready: no pop occurs, since rd_valid = 0. The entry appears on rd_data with rd_valid = 1 in the next cycle.
- Latency: a sample pushed at edge N is visible at the head from edge N onward, provided the FIFO was empty.
- Read: rd_data reflects mem[rd_ptr] combinationally from the registers (FWFT). On pop, rd_ptr increments and wraps.
- level: +1 on an accepted push without pop, -1 on pop without accepted push, otherwise unchanged. rd_valid = (level != 0).
- flush takes priority over push and pop. Pointers and level return to 0 at the next edge. A push in the flush cycle is neither stored nor counted. Counters are not cleared by flush.
- Counters saturate at 2^CNT_W - 1 and never wrap. match_cnt increments only on an accepted push with out0_in == out2_in.
- Reset mid-operation: immediate return to reset values, regardless of pending push, pop or flush.
- Inputs are already registered by the producer. No additional synchronisation is required.

Test Plan:
- Reset, then push 3 samples ({out2,out0} = 4'h1, 4'h6, 4'hF) with rd_ready = 0 -> level = 3, rd_data = 4'h1, accept_cnt = 3, match_cnt = 1 (4'hF only).
- Push 6 samples with rd_ready = 0, DEPTH = 4 -> full = 1, level = 4, accept_cnt = 4, drop_cnt = 2. Then drain with rd_ready = 1 -> first 4 values come out in order, and rd_valid = 0 after 4 pops.
- Fill to full, then push and pop in the same cycle -> level stays at 4, drop_cnt unchanged, and the new entry emerges 4 pops later. Wrap-around data is in the correct order.
- Push while empty with rd_ready = 1 -> rd_valid = 0 in that cycle and rd_valid = 1 next cycle with the pushed data. The pop completes one cycle later and level returns to 0.
- With level = 3, assert flush together with push -> next cycle level = 0, rd_valid = 0, accept_cnt unchanged.
- Continuous pushes while full for 300 cycles with CNT_W = 8 -> drop_cnt saturates at 255. Assert reset_n low mid-drain -> all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/if_collapse_result_buffer_if.sv
// Bundle between the if-collapse producer/consumer side and the result buffer.
//   producer side : out0_in, out1_in (push request), out2_in, flush
//   consumer side : rd_ready in, rd_valid/rd_data out
//   status        : level, full, accept_cnt, drop_cnt, match_cnt
// master = the side that drives producer/consumer requests (testbench or parent);
// slave  = the result buffer itself.
interface if_collapse_result_buffer_if #(
  parameter int BITS  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [BITS-1:0]   out0_in;
  logic              out1_in;
  logic [BITS-1:0]   out2_in;
  logic              flush;
  logic              rd_ready;
  logic              rd_valid;
  logic [2*BITS-1:0] rd_data;
  logic [LW-1:0]     level;
  logic              full;
  logic [CNT_W-1:0]  accept_cnt;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output out0_in, out1_in, out2_in, flush, rd_ready,
    input  rd_valid, rd_data, level, full, accept_cnt, drop_cnt, match_cnt
  );

  modport slave (
    input  out0_in, out1_in, out2_in, flush, rd_ready,
    output rd_valid, rd_data, level, full, accept_cnt, drop_cnt, match_cnt
  );
endinterface

// File: rtl/if_collapse_result_buffer.sv
// Result buffer behind the if-collapse producer: a small first-word-fall-through
// FIFO of qualified {out2, out0} samples plus saturating statistics.
// Ports:
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of if_collapse_result_buffer_if (push/flush inputs,
//             rd_ready/rd_valid/rd_data handshake, level/full and counters)
module if_collapse_result_buffer #(
  parameter int BITS  = 2,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  if_collapse_result_buffer_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = 2 * BITS;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [EW-1:0]    mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic push, pop, full, rd_valid, accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A full FIFO still takes a push when the head leaves in the same cycle.
  always_comb begin
    push     = bus.out1_in;
    rd_valid = (level_q != '0);
    full     = (level_q == FULL_LVL);
    pop      = rd_valid & bus.rd_ready;
    accept   = push & (~full | pop);
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    acc_cnt_d   = acc_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    match_cnt_d = match_cnt_q;
    if (bus.flush) begin
      // Flush wins: the push in this cycle is neither stored nor counted.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (accept) begin
        wr_ptr_d  = wr_ptr_q + 1'b1;
        acc_cnt_d = sat_inc(acc_cnt_q);
        if (bus.out0_in == bus.out2_in) match_cnt_d = sat_inc(match_cnt_q);
      end else if (push) begin
        drop_cnt_d = sat_inc(drop_cnt_q);
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (accept && !pop)      level_d = level_q + 1'b1;
      else if (pop && !accept) level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      acc_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      match_cnt_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      acc_cnt_q   <= acc_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  // Storage needs no reset: it is never observed while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (accept && !bus.flush) mem_q[wr_ptr_q] <= {bus.out2_in, bus.out0_in};
  end

  // Head is gated by rd_valid so rd_data reads 0 in reset and when empty.
  assign bus.rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.rd_valid   = rd_valid;
  assign bus.level      = level_q;
  assign bus.full       = full;
  assign bus.accept_cnt = acc_cnt_q;
  assign bus.drop_cnt   = drop_cnt_q;
  assign bus.match_cnt  = match_cnt_q;
endmodule

// File: tb/tb_if_collapse_result_buffer.sv
module tb_if_collapse_result_buffer;
  localparam int DEPTH = 4;
  localparam int CMAX  = 255;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_collapse_result_buffer_if #(.BITS(2), .DEPTH(DEPTH), .CNT_W(8)) bus();

  if_collapse_result_buffer #(.BITS(2), .DEPTH(DEPTH), .CNT_W(8)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Reference model: expected FIFO contents as a queue, counters as plain ints.
  logic [3:0] exp_q[$];
  int m_level, m_acc, m_drop, m_match;
  // Inputs applied at the upcoming edge; folded into the model one cycle later.
  bit         p_push, p_rdy, p_fl;
  logic [1:0] p_o0, p_o2;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Apply the effect of the edge that just passed (inputs held in p_*).
  // Pops are taken off exp_q by the monitor when it sees the handshake.
  task automatic model_step();
    bit pop_m, full_m;
    pop_m  = (m_level != 0) && p_rdy;
    full_m = (m_level == DEPTH);
    if (p_fl) begin
      m_level = 0;
      exp_q.delete();
    end else begin
      if (p_push && (!full_m || pop_m)) begin
        exp_q.push_back({p_o2, p_o0});
        m_acc = sat(m_acc);
        if (p_o0 == p_o2) m_match = sat(m_match);
        m_level++;
      end else if (p_push) begin
        m_drop = sat(m_drop);
      end
      if (pop_m) m_level--;
    end
  endtask

  task automatic cycle(input bit p, input logic [1:0] o0, input logic [1:0] o2,
                       input bit rdy, input bit fl);
    @(negedge clk);
    #1;
    model_step();
    p_push = p; p_o0 = o0; p_o2 = o2; p_rdy = rdy; p_fl = fl;
    bus.out1_in  = p;
    bus.out0_in  = o0;
    bus.out2_in  = o2;
    bus.rd_ready = rdy;
    bus.flush    = fl;
  endtask

  task automatic push(input logic [3:0] d, input bit rdy);
    cycle(1'b1, d[1:0], d[3:2], rdy, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 2'd0, 2'd0, rdy, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0; m_acc = 0; m_drop = 0; m_match = 0;
    p_push = 0; p_rdy = 0; p_fl = 0; p_o0 = 0; p_o2 = 0;
    bus.out1_in = 0; bus.out0_in = 0; bus.out2_in = 0;
    bus.rd_ready = 0; bus.flush = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".rd_valid"}, bus.rd_valid, 0);
    check({tag, ".rd_data"},  bus.rd_data, 0);
    check({tag, ".level"},    bus.level, 0);
    check({tag, ".full"},     bus.full, 0);
    check({tag, ".accept"},   bus.accept_cnt, 0);
    check({tag, ".drop"},     bus.drop_cnt, 0);
    check({tag, ".match"},    bus.match_cnt, 0);
  endtask

  // Monitor: runs after the driver has set this cycle's rd_ready, so a
  // handshake seen here is the pop that the next edge will perform.
  initial forever begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("mon.level",    bus.level, m_level);
      check("mon.full",     bus.full, (m_level == DEPTH));
      check("mon.rd_valid", bus.rd_valid, (m_level != 0));
      check("mon.accept",   bus.accept_cnt, m_acc);
      check("mon.drop",     bus.drop_cnt, m_drop);
      check("mon.match",    bus.match_cnt, m_match);
      if (bus.rd_valid && bus.rd_ready) begin
        if (exp_q.size() == 0) begin
          check("mon.pop_unexpected", 1, 0);
        end else begin
          check("mon.rd_data", bus.rd_data, exp_q.pop_front());
        end
      end
    end
  end

  int saved_drop;
  logic [3:0] d;

  initial begin
    rst_n = 1'b0;
    model_reset();
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;

    // Three pushes, no reader: 4'hF is the only out0 == out2 sample.
    push(4'h1, 0); push(4'h6, 0); push(4'hF, 0);
    idle(0);
    check("t1.level",  bus.level, 3);
    check("t1.head",   bus.rd_data, 4'h1);
    check("t1.accept", bus.accept_cnt, 3);
    check("t1.match",  bus.match_cnt, 1);

    // Flush with a simultaneous push: nothing stored, nothing counted.
    cycle(1'b1, 2'd2, 2'd1, 1'b0, 1'b1);
    idle(0);
    check("flush.level",    bus.level, 0);
    check("flush.rd_valid", bus.rd_valid, 0);
    check("flush.accept",   bus.accept_cnt, 3);

    // Overfill by two, then drain in order.
    for (int i = 0; i < 6; i++) push(4'($urandom), 0);
    idle(0);
    check("ovf.full",   bus.full, 1);
    check("ovf.level",  bus.level, 4);
    check("ovf.accept", bus.accept_cnt, 7);
    check("ovf.drop",   bus.drop_cnt, 2);
    repeat (4) idle(1);
    idle(0);
    check("drain.rd_valid", bus.rd_valid, 0);

    // Full with push and pop together: level holds, nothing dropped.
    for (int i = 0; i < 4; i++) push(4'($urandom), 0);
    idle(0);
    saved_drop = bus.drop_cnt;
    for (int i = 0; i < 3; i++) push(4'($urandom), 1);
    idle(0);
    check("pp.level", bus.level, 4);
    check("pp.drop",  bus.drop_cnt, saved_drop);
    repeat (5) idle(1);
    idle(0);

    // Push into empty FIFO with reader ready: visible only next cycle.
    d = 4'h9;
    push(d, 1);
    check("fwft.rd_valid_now", bus.rd_valid, 0);
    idle(1);
    check("fwft.rd_valid_next", bus.rd_valid, 1);
    check("fwft.rd_data", bus.rd_data, d);
    idle(0);
    check("fwft.level", bus.level, 0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 99) < 60, 2'($urandom), 2'($urandom),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
    end
    idle(1); idle(1); idle(1); idle(1); idle(0);

    // Hammer a full FIFO until drop_cnt pins at its maximum.
    for (int i = 0; i < 4 + 300; i++) push(4'($urandom), 0);
    idle(0);
    check("sat.drop", bus.drop_cnt, CMAX);
    check("sat.full", bus.full, 1);

    // Asynchronous reset in the middle of draining.
    idle(1); idle(1);
    #2;
    chk_en = 0;
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    push(4'hA, 0); push(4'h5, 1); idle(1); idle(1); idle(0);
    check("post_rst.accept", bus.accept_cnt, 2);
    check("post_rst.level",  bus.level, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
